// File: rtl/temp_sensor_if.sv
// ---------------------------------------------------------------------------
// temp_sensor_if
//
// Front end of the AC heating/cooling controller. Every SAMPLE_INTERVAL
// idle cycles it reads one byte from a read-only SPI-style temperature
// sensor, MSB first. The byte is clamped to the controller's 0..31 range and
// then smoothed with a 4-sample moving average. The filtered value is
// presented on `temp` and held until the next valid sample arrives.
//
// Parameters
//   SAMPLE_INTERVAL  idle clk cycles spent in WAIT between conversions (>=1)
//   SCLK_DIV         clk cycles per sclk half-period (>=1)
//   RESET_TEMP       temp value after reset, until the first valid sample
//
// Ports
//   clk         in   system clock, all logic on the rising edge
//   rst_n       in   asynchronous active-low reset
//   sdo         in   serial data from the sensor, MSB first
//   cs_n        out  sensor chip select, active low (registered)
//   sclk        out  sensor serial clock (registered)
//   temp        out  [4:0] filtered temperature, degrees C (registered)
//   temp_valid  out  one-cycle pulse when temp is updated
//   fault       out  sticky flag, set when the sensor returns 0xFF
//
// Conversion frame (SCLK_DIV = 2):
//   WAIT .. | SETUP | SHIFT x 16*SCLK_DIV | DONE | WAIT ..
//   cs_n is low during SETUP and SHIFT only; sclk idles low.
// ---------------------------------------------------------------------------
module temp_sensor_if #(
  parameter int         SAMPLE_INTERVAL = 1000,
  parameter int         SCLK_DIV        = 2,
  parameter logic [4:0] RESET_TEMP      = 5'd20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdo,
  output logic       cs_n,
  output logic       sclk,
  output logic [4:0] temp,
  output logic       temp_valid,
  output logic       fault
);

  // -------------------------------------------------------------------------
  // Local constants
  // -------------------------------------------------------------------------
  localparam int WAIT_W = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SAMPLE_INTERVAL - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);

  // A raw byte of all ones means nothing is driving sdo (sensor absent).
  localparam logic [7:0] RAW_ABSENT = 8'hFF;
  // Largest raw value that passes through unclamped.
  localparam logic [7:0] RAW_MAX    = 8'h1F;
  localparam logic [4:0] TEMP_MAX   = 5'd31;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Clamp a raw sensor byte into the controller range. 0xFF never reaches
  // here as a valid sample; it is filtered out as a fault beforehand.
  function automatic logic [4:0] sat_temp(input logic [7:0] raw);
    if (raw > RAW_MAX) begin
      return TEMP_MAX;
    end
    return raw[4:0];
  endfunction

  // Truncating mean of four 5-bit samples. 4*31 = 124 fits in 7 bits.
  function automatic logic [4:0] avg4(input logic [4:0] a,
                                      input logic [4:0] b,
                                      input logic [4:0] c,
                                      input logic [4:0] d);
    logic [6:0] sum;
    sum = 7'(a) + 7'(b) + 7'(c) + 7'(d);
    return 5'(sum >> 2);
  endfunction

  // -------------------------------------------------------------------------
  // Internal state
  // -------------------------------------------------------------------------
  state_t            state;
  state_t            state_next;

  logic [WAIT_W-1:0] wait_cnt;   // idle cycles elapsed in WAIT
  logic [DIV_W-1:0]  div_cnt;    // cycles elapsed in current sclk half-period
  logic [2:0]        bit_cnt;    // completed sclk periods in this byte
  logic [7:0]        shift_reg;  // bits captured so far, MSB first
  logic              primed;     // history holds at least one real sample
  logic [4:0]        hist [4];   // hist[0] newest .. hist[3] oldest

  // Decoded strobes from the output process
  logic              wait_done;
  logic              half_end;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              byte_done;
  logic              commit;
  logic              commit_ok;
  logic              cs_n_next;
  logic              sclk_next;
  logic [4:0]        sample_sat;
  logic [4:0]        temp_next;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      ST_WAIT:  if (wait_done) state_next = ST_SETUP;
      ST_SETUP: state_next = ST_SHIFT;
      ST_SHIFT: if (byte_done) state_next = ST_DONE;
      ST_DONE:  state_next = ST_WAIT;
      default:  state_next = ST_WAIT;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output / strobe decode
  //
  // The sclk register itself tells which half-period we are in: a half
  // ends when div_cnt reaches DIV_LAST, and the edge that closes a low
  // half is the one that raises sclk and captures sdo.
  // -------------------------------------------------------------------------
  always_comb begin
    wait_done  = (state == ST_WAIT) && (wait_cnt == WAIT_LAST);
    half_end   = (state == ST_SHIFT) && (div_cnt == DIV_LAST);
    sclk_rise  = half_end && !sclk;
    sclk_fall  = half_end && sclk;
    byte_done  = sclk_fall && (bit_cnt == 3'd7);
    commit     = (state == ST_DONE);
    commit_ok  = commit && (shift_reg != RAW_ABSENT);

    // Chip select is low for the whole of SETUP and SHIFT; driving it from
    // the next state keeps the pin registered and aligned with the FSM.
    cs_n_next  = !((state_next == ST_SETUP) || (state_next == ST_SHIFT));

    sclk_next  = 1'b0;
    if (state == ST_SHIFT) begin
      if (sclk_rise) begin
        sclk_next = 1'b1;
      end else if (sclk_fall) begin
        sclk_next = 1'b0;
      end else begin
        sclk_next = sclk;
      end
    end

    sample_sat = sat_temp(shift_reg);

    // First sample after reset fills all four taps, so the average equals
    // the sample itself.
    if (primed) begin
      temp_next = avg4(sample_sat, hist[0], hist[1], hist[2]);
    end else begin
      temp_next = sample_sat;
    end
  end

  // -------------------------------------------------------------------------
  // Interval and serial-clock counters
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == ST_WAIT) begin
        wait_cnt <= wait_done ? '0 : wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (state == ST_SHIFT) begin
        div_cnt <= half_end ? '0 : div_cnt + DIV_W'(1);
        if (sclk_fall) begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sensor pins
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n <= 1'b1;
      sclk <= 1'b0;
    end else begin
      cs_n <= cs_n_next;
      sclk <= sclk_next;
    end
  end

  // -------------------------------------------------------------------------
  // Serial capture: sdo is taken on the edge that raises sclk. The shifter
  // is data only; a partially filled byte is never committed, because a
  // reset sends the FSM back to WAIT and the next frame shifts in 8 fresh
  // bits before DONE is reached.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sclk_rise) begin
      shift_reg <= {shift_reg[6:0], sdo};
    end
  end

  // -------------------------------------------------------------------------
  // Filter history (data only; validity is tracked by `primed`)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (commit_ok) begin
      if (primed) begin
        hist[0] <= sample_sat;
        hist[1] <= hist[0];
        hist[2] <= hist[1];
        hist[3] <= hist[2];
      end else begin
        for (int i = 0; i < 4; i++) begin
          hist[i] <= sample_sat;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Result, valid pulse and fault flag, all updated on the edge leaving DONE
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp       <= RESET_TEMP;
      temp_valid <= 1'b0;
      fault      <= 1'b0;
      primed     <= 1'b0;
    end else begin
      temp_valid <= commit_ok;
      if (commit_ok) begin
        temp   <= temp_next;
        primed <= 1'b1;
      end
      // Sticky: once set, only reset clears it. Conversions keep running.
      if (commit && !commit_ok) begin
        fault <= 1'b1;
      end
    end
  end

endmodule

// File: doc/temp_sensor_if.md
Name: temp_sensor_if

Overview:
Upstream stage of the AC heating/cooling controller. It periodically reads an 8-bit temperature byte from a serial (SPI-style, read-only) sensor and saturates it to the controller's 0..31 range. It then low-pass filters the value with a 4-sample moving average. The result drives the controller's 5-bit temp input, held stable between updates.

Parameters:
SAMPLE_INTERVAL  1000  idle clk cycles in WAIT between conversions (>=1)
SCLK_DIV         2     clk cycles per sclk half-period (>=1)
RESET_TEMP       20    temp value after reset and until the first valid sample (0..31)

Ports:
clk         input   1  system clock, all logic on rising edge
rst_n       input   1  asynchronous, active-low reset
sdo         input   1  serial data from sensor, MSB first
cs_n        output  1  sensor chip select, active low
sclk        output  1  sensor serial clock
temp        output  5  filtered temperature to AC controller, degrees C
temp_valid  output  1  1-cycle pulse when temp updates
fault       output  1  sticky sensor-fault flag

Behaviour:
- Reset (rst_n=0, async): state=WAIT, wait counter=0, cs_n=1, sclk=0, temp=RESET_TEMP, temp_valid=0, fault=0, history empty (primed=0), bit counter=0.
- All outputs are registered; no combinational paths from sdo.
- WAIT:
  - Counter increments each cycle.
  - When counter==SAMPLE_INTERVAL-1: clear counter, go to SETUP.
  - First conversion starts SAMPLE_INTERVAL cycles after reset release.
- SETUP: 1 cycle; cs_n=0, sclk=0. Then SHIFT.
- SHIFT: 8 bits, each bit 2*SCLK_DIV cycles.
  - sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
  - sdo is sampled on the clk edge that drives sclk 0->1 and shifted into an 8-bit register, MSB first.
  - After the 8th high phase ends, sclk returns to 0. Go to DONE.
- DONE: 1 cycle; cs_n=1, filter update performed. Then WAIT.
- Conversion length: 2+16*SCLK_DIV cycles (34 at default). cs_n is low for exactly 1+16*SCLK_DIV cycles.
- Fault handling:
  - Raw byte 0xFF means sensor absent. Set fault=1; temp, history and temp_valid are unchanged.
  - fault is cleared only by reset.
  - Conversions continue while fault=1. Valid bytes still update temp.
- Saturation: raw byte 0x00..0x1F is passed through; 0x20..0xFE is clamped to 31.
- Filter:
  - 4-entry history of saturated samples.
  - First valid sample after reset (primed=0) loads all 4 entries with that sample and sets primed=1.
  - Afterwards, each valid sample shifts in and the oldest is dropped.
  - New temp = (sum of 4 entries) >> 2, truncating. The sum is 7 bits wide and never overflows (max 124).
- Update timing: temp and temp_valid=1 are registered on the edge leaving DONE. temp_valid is high exactly 1 cycle per valid conversion and never for a fault byte.
- Reset mid-conversion: immediate return to reset values.
  - cs_n=1 and sclk=0 are asserted asynchronously.
  - The partial byte is discarded.

Test Plan:
- Reset/hold: rst_n=0 then release, sdo=0 → temp=20, cs_n=1, sclk=0, fault=0. First cs_n fall occurs 1000 cycles after release; cs_n low 33 cycles; 8 sclk rising edges, period 4 clk.
- Priming: sensor model drives 0x15 → one temp_valid pulse, temp=21. Next conversions of 0x19,0x19,0x19 → temp=22,23,24. A fourth 0x19 → temp=25.
- Saturation/truncation: prime with 0x0F (temp=15), then 0x40 → history {31,15,15,15}, temp=19. Then 0xFE → {31,31,15,15}, temp=23.
- Fault: after temp=21, sensor sends 0xFF → fault=1, no temp_valid, temp stays 21. Next byte 0x19 → temp=22, fault stays 1.
- Reset mid-SHIFT: assert rst_n=0 after 3 sclk rising edges → cs_n=1 and sclk=0 immediately, temp=20, history unprimed. Next conversion of 0x1E → temp=30.
- End-to-end with AC: temp_sensor_if temp drives AC temp; sensor sequence 0x0F,0x15,0x19,0x13. Each cycle: never h=1 and c=1 together; h=0 whenever temp>=20; c=0 whenever temp<=20.
